// File: rtl/div_rs.sv
// Reservation station for the sequential divide unit: a collapsing queue (entry 0 oldest)
// with CDB wakeup, dispatch-time CDB bypass and oldest-ready issue to the divider.
package div_rs_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_op_t;
endpackage

module div_rs
    import div_rs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  div_op_t                    dispatch_op,
    input  logic [PREG_W-1:0]          dispatch_src1_preg,
    input  logic                       dispatch_src1_rdy,
    input  logic [31:0]                dispatch_src1_data,
    input  logic [PREG_W-1:0]          dispatch_src2_preg,
    input  logic                       dispatch_src2_rdy,
    input  logic [31:0]                dispatch_src2_data,
    input  logic [PREG_W-1:0]          dispatch_dest_preg,
    input  logic [ROB_W-1:0]           dispatch_rob_id,
    input  logic                       cdb_valid,
    input  logic [PREG_W-1:0]          cdb_preg,
    input  logic [31:0]                cdb_data,
    input  logic                       div_busy,
    output logic                       issue_valid,
    output logic [31:0]                issue_dividend,
    output logic [31:0]                issue_divisor,
    output div_op_t                    issue_op,
    output logic [PREG_W-1:0]          issue_dest_preg,
    output logic [ROB_W-1:0]           issue_rob_id,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    // Handshakes: dispatch transfers on a cycle where dispatch_valid && dispatch_ready;
    // issue transfers on every cycle issue_valid is high (it already folds in !div_busy).
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic              rdy;
        logic [31:0]       data;
    } src_t;

    typedef struct packed {
        logic              valid;
        div_op_t           op;
        src_t              src1;
        src_t              src2;
        logic [PREG_W-1:0] dest_preg;
        logic [ROB_W-1:0]  rob_id;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // woken[DEPTH] is an always-empty slot that shifts into the top entry on issue.
    entry_t           woken [DEPTH+1];
    entry_t           new_ent;
    entry_t           out_ent;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] wr_idx;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic             accept;

    function automatic src_t wake(input src_t s, input logic cv,
                                  input logic [PREG_W-1:0] cp, input logic [31:0] cd);
        src_t r;
        r = s;
        if (!s.rdy && cv && (s.preg == cp)) begin
            r.rdy  = 1'b1;
            r.data = cd;
        end
        return r;
    endfunction

    // Lowest-index entry with both operands ready, from registered state only.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_valid    = cand_found && !div_busy && !flush;
    assign dispatch_ready = (occ_q < DEPTH_C) && !flush;
    assign accept         = dispatch_valid && dispatch_ready;
    assign wr_idx         = issue_valid ? (occ_q - CNT_W'(1)) : occ_q;
    assign occupancy      = occ_q;

    // Preg 0 is architecturally ready; otherwise a same-cycle broadcast is bypassed in.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.op        = dispatch_op;
        new_ent.src1      = wake('{preg: dispatch_src1_preg,
                                   rdy:  dispatch_src1_rdy || (dispatch_src1_preg == '0),
                                   data: dispatch_src1_data},
                                 cdb_valid, cdb_preg, cdb_data);
        new_ent.src2      = wake('{preg: dispatch_src2_preg,
                                   rdy:  dispatch_src2_rdy || (dispatch_src2_preg == '0),
                                   data: dispatch_src2_data},
                                 cdb_valid, cdb_preg, cdb_data);
        new_ent.dest_preg = dispatch_dest_preg;
        new_ent.rob_id    = dispatch_rob_id;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]      = ent_q[i];
            woken[i].src1 = wake(ent_q[i].src1, cdb_valid && ent_q[i].valid, cdb_preg, cdb_data);
            woken[i].src2 = wake(ent_q[i].src2, cdb_valid && ent_q[i].valid, cdb_preg, cdb_data);
        end
        woken[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (issue_valid && (i >= int'(cand_idx))) ent_d[i] = woken[i+1];
            else                                      ent_d[i] = woken[i];
            if (accept && (i == int'(wr_idx))) ent_d[i] = new_ent;
            if (flush) ent_d[i] = '0;
        end

        occ_d = occ_q + CNT_W'(accept) - CNT_W'(issue_valid);
        if (flush) occ_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            occ_q <= occ_d;
        end
    end

    // Idle outputs mirror the head entry so the divider side sees stable values.
    always_comb begin
        out_ent = '0;
        if (issue_valid)         out_ent = ent_q[cand_idx];
        else if (ent_q[0].valid) out_ent = ent_q[0];
    end

    assign issue_dividend  = out_ent.src1.data;
    assign issue_divisor   = out_ent.src2.data;
    assign issue_op        = out_ent.op;
    assign issue_dest_preg = out_ent.dest_preg;
    assign issue_rob_id    = out_ent.rob_id;

endmodule

// File: tb/tb_div_rs.sv
// Bench for div_rs: queue-based reference model predicts each issue, a monitor
// compares DUT issues against the expected queue; directed cases then random traffic.
module tb_div_rs;
    import div_rs_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int EXP_W  = 2 + 32 + 32 + PREG_W + ROB_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              dispatch_valid = 1'b0;
    logic              dispatch_ready;
    div_op_t           dispatch_op = DIV_DIV;
    logic [PREG_W-1:0] dispatch_src1_preg = '0;
    logic              dispatch_src1_rdy = 1'b0;
    logic [31:0]       dispatch_src1_data = '0;
    logic [PREG_W-1:0] dispatch_src2_preg = '0;
    logic              dispatch_src2_rdy = 1'b0;
    logic [31:0]       dispatch_src2_data = '0;
    logic [PREG_W-1:0] dispatch_dest_preg = '0;
    logic [ROB_W-1:0]  dispatch_rob_id = '0;
    logic              cdb_valid = 1'b0;
    logic [PREG_W-1:0] cdb_preg = '0;
    logic [31:0]       cdb_data = '0;
    logic              div_busy = 1'b0;
    logic              issue_valid;
    logic [31:0]       issue_dividend;
    logic [31:0]       issue_divisor;
    div_op_t           issue_op;
    logic [PREG_W-1:0] issue_dest_preg;
    logic [ROB_W-1:0]  issue_rob_id;
    logic [CNT_W-1:0]  occupancy;

    div_rs #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op),
        .dispatch_src1_preg(dispatch_src1_preg), .dispatch_src1_rdy(dispatch_src1_rdy),
        .dispatch_src1_data(dispatch_src1_data),
        .dispatch_src2_preg(dispatch_src2_preg), .dispatch_src2_rdy(dispatch_src2_rdy),
        .dispatch_src2_data(dispatch_src2_data),
        .dispatch_dest_preg(dispatch_dest_preg), .dispatch_rob_id(dispatch_rob_id),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
        .div_busy(div_busy), .issue_valid(issue_valid),
        .issue_dividend(issue_dividend), .issue_divisor(issue_divisor),
        .issue_op(issue_op), .issue_dest_preg(issue_dest_preg),
        .issue_rob_id(issue_rob_id), .occupancy(occupancy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [1:0]        op;
        logic [PREG_W-1:0] p1;
        logic              r1;
        logic [31:0]       d1;
        logic [PREG_W-1:0] p2;
        logic              r2;
        logic [31:0]       d2;
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob;
    } m_ent_t;

    m_ent_t           m_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int               vectors = 0;
    int               miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model step: pending ops kept in age order; at each cycle the first op whose
    // operands are both known leaves (if the divider is free), broadcasts fill in
    // operands, and a new op joins the tail if there was room.
    always @(negedge clk or negedge rst_n) begin : model
        int     sel;
        logic   room;
        m_ent_t e;
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
        end else begin
            check("occupancy", 64'(occupancy), 64'(m_q.size()));
            room = (m_q.size() < DEPTH);
            check("dispatch_ready", 64'(dispatch_ready), 64'(room && !flush));
            if (!issue_valid) begin
                if (m_q.size() == 0)
                    check("idle_empty", {issue_dividend, issue_divisor}, 64'd0);
                else
                    check("idle_head", {issue_dividend, issue_divisor}, {m_q[0].d1, m_q[0].d2});
            end
            if (flush) begin
                m_q.delete();
            end else begin
                sel = -1;
                for (int k = 0; k < m_q.size(); k++)
                    if (sel < 0 && m_q[k].r1 && m_q[k].r2) sel = k;
                if (sel >= 0 && !div_busy) begin
                    e = m_q[sel];
                    exp_q.push_back({e.op, e.d1, e.d2, e.dest, e.rob});
                    m_q.delete(sel);
                end
                for (int k = 0; k < m_q.size(); k++) begin
                    if (cdb_valid && !m_q[k].r1 && m_q[k].p1 == cdb_preg) begin
                        m_q[k].r1 = 1'b1; m_q[k].d1 = cdb_data;
                    end
                    if (cdb_valid && !m_q[k].r2 && m_q[k].p2 == cdb_preg) begin
                        m_q[k].r2 = 1'b1; m_q[k].d2 = cdb_data;
                    end
                end
                if (dispatch_valid && room) begin
                    e.op = dispatch_op;
                    e.p1 = dispatch_src1_preg;
                    e.r1 = dispatch_src1_rdy || dispatch_src1_preg == 0;
                    e.d1 = dispatch_src1_data;
                    e.p2 = dispatch_src2_preg;
                    e.r2 = dispatch_src2_rdy || dispatch_src2_preg == 0;
                    e.d2 = dispatch_src2_data;
                    if (!e.r1 && cdb_valid && e.p1 == cdb_preg) begin e.r1 = 1'b1; e.d1 = cdb_data; end
                    if (!e.r2 && cdb_valid && e.p2 == cdb_preg) begin e.r2 = 1'b1; e.d2 = cdb_data; end
                    e.dest = dispatch_dest_preg;
                    e.rob  = dispatch_rob_id;
                    m_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the expected queue.
    always @(negedge clk) begin : monitor
        logic [EXP_W-1:0] exp_v;
        #1;
        if (rst_n) begin
            check("issue_valid", 64'(issue_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                if (issue_valid) begin
                    check("issue_op",       64'(issue_op),        64'(exp_v[EXP_W-1 -: 2]));
                    check("issue_dividend", 64'(issue_dividend),  64'(exp_v[EXP_W-3 -: 32]));
                    check("issue_divisor",  64'(issue_divisor),   64'(exp_v[EXP_W-35 -: 32]));
                    check("issue_dest",     64'(issue_dest_preg), 64'(exp_v[PREG_W+ROB_W-1 -: PREG_W]));
                    check("issue_rob",      64'(issue_rob_id),    64'(exp_v[ROB_W-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dispatch(input div_op_t op,
                            input logic [PREG_W-1:0] p1, input logic r1, input logic [31:0] d1,
                            input logic [PREG_W-1:0] p2, input logic r2, input logic [31:0] d2,
                            input logic [PREG_W-1:0] dest, input logic [ROB_W-1:0] rob);
        dispatch_valid     = 1'b1;
        dispatch_op        = op;
        dispatch_src1_preg = p1; dispatch_src1_rdy = r1; dispatch_src1_data = d1;
        dispatch_src2_preg = p2; dispatch_src2_rdy = r2; dispatch_src2_data = d2;
        dispatch_dest_preg = dest;
        dispatch_rob_id    = rob;
        cyc();
        dispatch_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [PREG_W-1:0] p, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_preg = p; cdb_data = d;
        cyc();
        cdb_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("reset_issue_valid", 64'(issue_valid), 64'd0);
        check("reset_ready",       64'(dispatch_ready), 64'd1);
        check("reset_occupancy",   64'(occupancy), 64'd0);
        check("reset_data",        {issue_dividend, issue_divisor}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // Single ready op issues the cycle after dispatch.
        dispatch(DIV_DIV, 6'd1, 1'b1, 32'd100, 6'd2, 1'b1, 32'd7, 6'd3, 5'd1);
        cyc(3);

        // Fill with divisor waiting on preg 9, overflow attempt, then one broadcast.
        div_busy = 1'b1;
        for (int k = 0; k < DEPTH; k++)
            dispatch(div_op_t'(k % 4), 6'd1, 1'b1, 32'(200 + k), 6'd9, 1'b0, 32'd0,
                     6'(10 + k), 5'(2 + k));
        check("full_ready", 64'(dispatch_ready), 64'd0);
        dispatch(DIV_REM, 6'd1, 1'b1, 32'd999, 6'd2, 1'b1, 32'd1, 6'd20, 5'd9);
        broadcast(6'd9, 32'd3);
        for (int k = 0; k < DEPTH; k++) begin
            div_busy = 1'b0; cyc();
            div_busy = 1'b1; cyc(3);
        end
        div_busy = 1'b0;
        cyc(2);

        // Younger ready op bypasses an older blocked one.
        div_busy = 1'b1;
        dispatch(DIV_DIVU, 6'd20, 1'b0, 32'd0, 6'd2, 1'b1, 32'd5, 6'd21, 5'd10);
        dispatch(DIV_REMU, 6'd1, 1'b1, 32'd55, 6'd2, 1'b1, 32'd6, 6'd22, 5'd11);
        div_busy = 1'b0;
        cyc(2);
        broadcast(6'd20, 32'd77);
        cyc(2);

        // Dispatch-time bypass from the CDB.
        div_busy = 1'b1;
        cdb_valid = 1'b1; cdb_preg = 6'd12; cdb_data = 32'hDEAD;
        dispatch(DIV_DIV, 6'd12, 1'b0, 32'h1111, 6'd2, 1'b1, 32'd4, 6'd23, 5'd12);
        cdb_valid = 1'b0;
        div_busy = 1'b0;
        cyc(2);

        // Long busy window, then issue in the same cycle busy drops.
        div_busy = 1'b1;
        dispatch(DIV_REM, 6'd1, 1'b1, 32'd81, 6'd2, 1'b1, 32'd9, 6'd24, 5'd13);
        cyc(20);
        div_busy = 1'b0;
        #1;
        check("busy_drop_issue", 64'(issue_valid), 64'd1);
        cyc(2);

        // Flush with a dispatch and an issuable entry in the same cycle.
        div_busy = 1'b1;
        for (int k = 0; k < 3; k++)
            dispatch(DIV_DIV, 6'd1, 1'b1, 32'(300 + k), 6'd2, 1'b1, 32'd3, 6'(30 + k), 5'(14 + k));
        div_busy = 1'b0;
        flush = 1'b1;
        dispatch(DIV_DIVU, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1, 6'd40, 5'd20);
        flush = 1'b0;
        cyc(2);

        // Asynchronous reset pulse mid-cycle while an issue is being presented.
        div_busy = 1'b1;
        dispatch(DIV_DIV, 6'd1, 1'b1, 32'd64, 6'd2, 1'b1, 32'd8, 6'd41, 5'd21);
        dispatch(DIV_DIV, 6'd1, 1'b1, 32'd65, 6'd2, 1'b1, 32'd8, 6'd42, 5'd22);
        div_busy = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_pulse_issue", 64'(issue_valid), 64'd0);
        check("rst_pulse_occ",   64'(occupancy), 64'd0);
        check("rst_pulse_ready", 64'(dispatch_ready), 64'd1);
        check("rst_pulse_data",  {issue_dividend, issue_divisor}, 64'd0);
        #1 rst_n = 1'b1;
        cyc(2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            dispatch_valid     = ($urandom_range(0, 2) != 0);
            dispatch_op        = div_op_t'($urandom_range(0, 3));
            dispatch_src1_preg = 6'($urandom_range(0, 15));
            dispatch_src1_rdy  = ($urandom_range(0, 1) == 1);
            dispatch_src1_data = $urandom;
            dispatch_src2_preg = 6'($urandom_range(0, 15));
            dispatch_src2_rdy  = ($urandom_range(0, 1) == 1);
            dispatch_src2_data = $urandom;
            dispatch_dest_preg = 6'($urandom_range(1, 63));
            dispatch_rob_id    = 5'($urandom_range(0, 31));
            cdb_valid          = ($urandom_range(0, 1) == 1);
            cdb_preg           = 6'($urandom_range(1, 15));
            cdb_data           = $urandom;
            div_busy           = ($urandom_range(0, 2) == 0);
            flush              = ($urandom_range(0, 39) == 0);
            cyc();
        end
        dispatch_valid = 1'b0;
        flush = 1'b0;
        div_busy = 1'b0;
        for (int p = 1; p < 16; p++) broadcast(6'(p), 32'(p * 1000));
        cyc(DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
